lmu_measacc: RTL
================

// Module: lmu_measacc
// PURPOSE
//  Sequencer/accumulator directly upstream and downstream of lmu_selproduct in the baseline LMU.
//  Accepts one logical-measurement job (list of sel_meas entries), drives the entries to
//  lmu_selproduct one per cycle, XOR-accumulates the returned initial_meas, and emits one
//  logical measurement bit over a valid/ready handshake.
// PARAMETERS
//  SELMEAS_BW  6  width of one sel_meas entry {sel_loc, sel_dqaq, sel_xz, sel_valid}; equals `SELMEAS_BW
//  MAX_SEL     4  max entries per job
//  CNT_BW      3  width of entry count/index; must hold MAX_SEL
// PORTS
//  clk            in   1                  clock; all state updates on rising edge
//  rst            in   1                  synchronous, active-high reset
//  in_valid       in   1                  job offered
//  in_ready       out  1                  block can accept a job
//  in_sel_list    in   MAX_SEL*SELMEAS_BW entry i at [i*SELMEAS_BW +: SELMEAS_BW]
//  in_num_sel     in   CNT_BW             number of entries in the job (0..MAX_SEL)
//  in_reverse     in   1                  sel_reverse for the whole job
//  in_flip        in   1                  XOR-ed into the final result
//  sel_meas       out  SELMEAS_BW         to lmu_selproduct.sel_meas (registered)
//  sel_reverse    out  1                  to lmu_selproduct.sel_reverse (registered)
//  initial_meas   in   1                  from lmu_selproduct (combinational from sel_meas)
//  out_valid      out  1                  result available
//  out_ready      in   1                  consumer accepts result
//  out_result     out  1                  logical measurement bit
//  busy           out  1                  high in DRIVE or DONE
// BEHAVIOUR
//  Reset: state IDLE; sel_meas=0, sel_reverse=0, out_valid=0, out_result=0, busy=0,
//   in_ready=1 from the first cycle after rst deasserts; rst mid-job discards the job, no output.
//  States: IDLE -> DRIVE -> DONE -> IDLE; IDLE -> DONE directly when the job is empty.
//  IDLE: in_ready=1. On in_valid: latch list, reverse, flip; n = min(in_num_sel, MAX_SEL).
//   n==0: acc<=flip, go DONE. Else sel_meas<=entry0, sel_reverse<=in_reverse, idx<=0, acc<=flip, go DRIVE.
//  DRIVE: in_ready=0. Each cycle acc ^= (sel_meas[0] ? initial_meas : 0).
//   sel_valid=0 entries use one cycle and contribute 0.
//   If idx==n-1: sel_meas<=0, go DONE. Else idx++, sel_meas<=entry[idx+1].
//  DONE: out_valid=1, out_result=acc, held stable until out_ready.
//   On out_valid&out_ready: go IDLE, out_valid<=0. in_ready=0 in DONE; no same-cycle reload.
//  Latency: job accepted at cycle T with n>=1 -> out_valid first high at T+n+1; n==0 -> T+1.
//   Throughput: one job per n+2 cycles minimum.
//  sel_meas=0 (sel_valid=0) outside DRIVE, so lmu_selproduct contributes nothing while idle.
//  in_num_sel>MAX_SEL is clamped to MAX_SEL; entries above n are ignored.
//  initial_meas is sampled only in DRIVE; its value in other states is don't-care.
// TESTING
//  1) n=3, entries all valid, initial_meas=1,0,1 in DRIVE, flip=0 -> out_result=0, out_valid at T+4.
//  2) n=2, entry1 sel_valid=0, initial_meas forced 1 both cycles, flip=1 -> out_result=0.
//  3) n=0, flip=1 -> out_valid at T+1, out_result=1, sel_meas stays 0 throughout.
//  4) out_ready held low 5 cycles in DONE -> out_valid/out_result stable, in_ready=0,
//     in_valid ignored; after out_ready=1 the next job is accepted 1 cycle later.
//  5) rst pulsed on the 2nd DRIVE cycle -> next cycle IDLE, sel_meas=0, out_valid=0, in_ready=1.
//  6) in_num_sel=7 with MAX_SEL=4 -> exactly 4 entries driven, out_valid at T+5.

Source files
------------

// File: rtl/lmu_measacc.sv
// Sequences one logical-measurement job into lmu_selproduct and
// XOR-accumulates the returned initial_meas into one result bit.
module lmu_measacc #(
  parameter int SELMEAS_BW = 6,
  parameter int MAX_SEL    = 4,
  parameter int CNT_BW     = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_SEL*SELMEAS_BW-1:0] in_sel_list,
  input  logic [CNT_BW-1:0]             in_num_sel,
  input  logic                          in_reverse,
  input  logic                          in_flip,
  output logic [SELMEAS_BW-1:0]         sel_meas,
  output logic                          sel_reverse,
  input  logic                          initial_meas,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_result,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [MAX_SEL*SELMEAS_BW-1:0] list_q;
  logic [CNT_BW-1:0]             idx_q;
  logic [CNT_BW-1:0]             n_q;
  logic                          acc_q;
  logic [CNT_BW-1:0]             n_in;
  logic [CNT_BW-1:0]             last_idx;
  logic [CNT_BW-1:0]             nxt_idx;
  logic [SELMEAS_BW-1:0]         nxt_entry;
  logic                          at_last;

  // Oversized job counts are clamped rather than rejected.
  assign n_in = (in_num_sel > CNT_BW'(MAX_SEL)) ? CNT_BW'(MAX_SEL)
                                                 : in_num_sel;

  assign last_idx = n_q - CNT_BW'(1);
  assign nxt_idx  = idx_q + CNT_BW'(1);
  assign at_last  = (idx_q == last_idx);

  always_comb begin
    nxt_entry = '0;
    for (int i = 0; i < MAX_SEL; i++) begin
      if (CNT_BW'(i) == nxt_idx)
        nxt_entry = list_q[i*SELMEAS_BW +: SELMEAS_BW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid)
          state_d = (n_in == '0) ? DONE : DRIVE;
      end
      DRIVE: begin
        if (at_last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      list_q      <= '0;
      idx_q       <= '0;
      n_q         <= '0;
      acc_q       <= 1'b0;
      sel_meas    <= '0;
      sel_reverse <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            list_q <= in_sel_list;
            n_q    <= n_in;
            idx_q  <= '0;
            acc_q  <= in_flip;
            if (n_in != '0) begin
              sel_meas    <= in_sel_list[SELMEAS_BW-1:0];
              sel_reverse <= in_reverse;
            end
          end
        end
        DRIVE: begin
          // Invalid entries gate off whatever selproduct returns.
          acc_q <= acc_q ^ (sel_meas[0] & initial_meas);
          if (at_last) begin
            sel_meas <= '0;
          end else begin
            idx_q    <= nxt_idx;
            sel_meas <= nxt_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = (state_q == DONE) & acc_q;
  assign busy       = (state_q != IDLE);

endmodule
